// File: rtl/exe_stage_if.sv
// rtl/exe_stage_if.sv - decode->EX and EX->MEM handshake links seen by the execute stage
interface exe_stage_if;
    logic         ds2es_valid;
    logic         es_allowin;
    logic [151:0] ds2es_bus;
    logic         ms_allowin;
    logic         es2ms_valid;
    logic [70:0]  es2ms_bus;

    modport master (
        output ds2es_valid, ds2es_bus, ms_allowin,
        input  es_allowin, es2ms_valid, es2ms_bus
    );
    modport slave (
        input  ds2es_valid, ds2es_bus, ms_allowin,
        output es_allowin, es2ms_valid, es2ms_bus
    );
endinterface

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: one-hot ALU, 32-step restoring divider, data SRAM request
module exe_stage (
    input  logic        clk,
    input  logic        reset,
    exe_stage_if.slave  pipe,
    output logic        es_valid,
    output logic        exe_gr_we,
    output logic [4:0]  exe_dest,
    output logic        exe_res_from_mem,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_we,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

    logic [31:0] es_pc, es_src1, es_src2, es_rkd;
    logic [11:0] es_alu_op;
    logic [3:0]  es_div_op;
    logic        es_mem_we;
    logic        es_ready_go, div_start, div_step;
    logic [31:0] alu_out, div_result, alu_result;

    div_state_t  div_state, div_state_nxt;
    logic [31:0] div_quo, div_rem, div_dsr;
    logic [4:0]  div_cnt;
    logic        div_neg_q, div_neg_r;

    assign pipe.es_allowin  = ~es_valid | (es_ready_go & pipe.ms_allowin);
    assign pipe.es2ms_valid = es_valid & es_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid         <= 1'b0;
            es_pc            <= '0;
            es_alu_op        <= '0;
            es_div_op        <= '0;
            es_src1          <= '0;
            es_src2          <= '0;
            es_rkd           <= '0;
            exe_res_from_mem <= 1'b0;
            es_mem_we        <= 1'b0;
            exe_dest         <= '0;
            exe_gr_we        <= 1'b0;
        end else begin
            if (pipe.es_allowin) es_valid <= pipe.ds2es_valid;
            if (pipe.ds2es_valid & pipe.es_allowin) begin
                {es_pc, es_alu_op, es_div_op, es_src1, es_src2, es_rkd,
                 exe_res_from_mem, es_mem_we, exe_dest, exe_gr_we} <= pipe.ds2es_bus;
            end
        end
    end

    // alu_op is one-hot; an all-zero op falls through to 0
    always_comb begin
        alu_out = 32'd0;
        if (es_alu_op[0])  alu_out = es_src1 + es_src2;
        if (es_alu_op[1])  alu_out = es_src1 - es_src2;
        if (es_alu_op[2])  alu_out = {31'd0, $signed(es_src1) < $signed(es_src2)};
        if (es_alu_op[3])  alu_out = {31'd0, es_src1 < es_src2};
        if (es_alu_op[4])  alu_out = es_src1 & es_src2;
        if (es_alu_op[5])  alu_out = ~(es_src1 | es_src2);
        if (es_alu_op[6])  alu_out = es_src1 | es_src2;
        if (es_alu_op[7])  alu_out = es_src1 ^ es_src2;
        if (es_alu_op[8])  alu_out = es_src1 << es_src2[4:0];
        if (es_alu_op[9])  alu_out = es_src1 >> es_src2[4:0];
        if (es_alu_op[10]) alu_out = $signed(es_src1) >>> es_src2[4:0];
        if (es_alu_op[11]) alu_out = es_src2;
    end

    always_ff @(posedge clk) begin
        if (reset) div_state <= S_IDLE;
        else       div_state <= div_state_nxt;
    end

    always_comb begin
        div_state_nxt = div_state;
        case (div_state)
            S_IDLE:  if (div_start) div_state_nxt = S_BUSY;
            S_BUSY:  if (div_cnt == 5'd31) div_state_nxt = S_DONE;
            S_DONE:  if (es_ready_go & pipe.ms_allowin) div_state_nxt = S_IDLE;
            default: div_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        es_ready_go = (es_div_op == 4'd0) | (div_state == S_DONE);
        div_start   = (div_state == S_IDLE) & es_valid & (es_div_op != 4'd0);
        div_step    = (div_state == S_BUSY);
    end

    logic        div_signed;
    logic [32:0] div_trial;
    logic        div_fit;
    logic [31:0] div_sub;

    assign div_signed = es_div_op[0] | es_div_op[1];
    // div_quo shifts the dividend out MSB-first while quotient bits shift in
    assign div_trial  = {div_rem, div_quo[31]};
    assign div_fit    = div_trial >= {1'b0, div_dsr};
    assign div_sub    = div_trial[31:0] - div_dsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_quo   <= '0;
            div_rem   <= '0;
            div_dsr   <= '0;
            div_cnt   <= '0;
            div_neg_q <= 1'b0;
            div_neg_r <= 1'b0;
        end else if (div_start) begin
            div_quo   <= (div_signed & es_src1[31]) ? -es_src1 : es_src1;
            div_dsr   <= (div_signed & es_src2[31]) ? -es_src2 : es_src2;
            div_rem   <= '0;
            div_cnt   <= '0;
            div_neg_q <= div_signed & (es_src1[31] ^ es_src2[31]);
            div_neg_r <= div_signed & es_src1[31];
        end else if (div_step) begin
            div_rem <= div_fit ? div_sub : div_trial[31:0];
            div_quo <= {div_quo[30:0], div_fit};
            div_cnt <= div_cnt + 5'd1;
        end
    end

    always_comb begin
        if (es_div_op[1] | es_div_op[3]) div_result = div_neg_r ? -div_rem : div_rem;
        else                             div_result = div_neg_q ? -div_quo : div_quo;
        alu_result = (es_div_op != 4'd0) ? div_result : alu_out;
    end

    assign pipe.es2ms_bus = {es_pc, alu_result, exe_res_from_mem, exe_dest, exe_gr_we};

    assign data_sram_en    = es_valid & (exe_res_from_mem | es_mem_we) & pipe.ms_allowin;
    assign data_sram_we    = {4{es_valid & es_mem_we & pipe.ms_allowin}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = es_rkd;
endmodule
